// File: rtl/tmds_gearbox_serializer.sv
// ---------------------------------------------------------------------------
// tmds_gearbox_serializer
//
// Purpose:
//   Single-clock parallel-to-lane gearbox for an HDMI/DVI output path.
//   NUM_CHANNELS TMDS symbols arrive together on a valid/ready beat and are
//   buffered in a small FIFO. Every clock edge one LANE_WIDTH slice of each
//   channel's current symbol is presented on lane_out_o, ready for a DDR/SDR
//   pad stage or a generic output serializer. A matching pixel-clock pattern
//   slice is presented on clk_lane_o. When no symbol is available at a word
//   boundary, IDLE_WORD is transmitted on every channel instead.
//
// Ports:
//   clk_pixel_x5_i   bit-rate clock, one slice per rising edge
//   reset_n_i        synchronous active-low reset
//   enable_i         1: consume FIFO; 0: transmit IDLE_WORD, FIFO held
//   in_valid_i       in_data_i carries a valid beat
//   in_ready_o       FIFO can accept a beat
//   in_data_i        channel c symbol at [c*WORD_WIDTH +: WORD_WIDTH]
//   lane_out_o       channel c slice at [c*LANE_WIDTH +: LANE_WIDTH], bit 0 earliest
//   clk_lane_o       pixel-clock pattern slice, aligned with lane_out_o
//   word_start_o     high while the first slice of a symbol is on lane_out_o
//   underflow_o      sticky flag: IDLE_WORD inserted while enabled
//   underflow_cnt_o  saturating count of such insertions
//   fifo_level_o     number of symbols currently buffered
// ---------------------------------------------------------------------------
module tmds_gearbox_serializer #(
  parameter int                    NUM_CHANNELS = 3,
  parameter int                    WORD_WIDTH   = 10,
  parameter int                    LANE_WIDTH   = 2,
  parameter int                    FIFO_DEPTH   = 4,
  parameter bit                    MSB_FIRST    = 1'b0,
  parameter logic [WORD_WIDTH-1:0] IDLE_WORD    = 10'b1101010100
) (
  input  logic                               clk_pixel_x5_i,
  input  logic                               reset_n_i,
  input  logic                               enable_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [NUM_CHANNELS*WORD_WIDTH-1:0] in_data_i,
  output logic [NUM_CHANNELS*LANE_WIDTH-1:0] lane_out_o,
  output logic [LANE_WIDTH-1:0]              clk_lane_o,
  output logic                               word_start_o,
  output logic                               underflow_o,
  output logic [7:0]                         underflow_cnt_o,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level_o
);

  // -------------------------------------------------------------------------
  // Derived constants
  // -------------------------------------------------------------------------
  localparam int BEATS = WORD_WIDTH / LANE_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int DW    = NUM_CHANNELS * WORD_WIDTH;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);

  // Pixel-clock pattern: the low half of the symbol period is high.
  function automatic logic [WORD_WIDTH-1:0] clk_pattern_f();
    logic [WORD_WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      p[i] = (i < (WORD_WIDTH / 2)) ? 1'b1 : 1'b0;
    end
    return p;
  endfunction

  // Mirrors a symbol so that its MSB ends up in bit 0 (sent first).
  function automatic logic [WORD_WIDTH-1:0] bit_reverse_f(input logic [WORD_WIDTH-1:0] w);
    logic [WORD_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      r[i] = w[WORD_WIDTH-1-i];
    end
    return r;
  endfunction

  localparam logic [WORD_WIDTH-1:0] CLK_PATTERN = clk_pattern_f();

  // -------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // -------------------------------------------------------------------------
  if ((WORD_WIDTH % LANE_WIDTH) != 0) begin : g_bad_lane_width
    $error("tmds_gearbox_serializer: WORD_WIDTH must be a multiple of LANE_WIDTH");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
    $error("tmds_gearbox_serializer: FIFO_DEPTH must be a power of two >= 2");
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic                  reset_n_q;
  logic [CNT_W-1:0]      beat_q,   beat_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      count_q,  count_d;
  logic [DW-1:0]         mem_q [FIFO_DEPTH];
  logic [WORD_WIDTH-1:0] shift_q [NUM_CHANNELS];
  logic [WORD_WIDTH-1:0] shift_d [NUM_CHANNELS];
  logic [WORD_WIDTH-1:0] clk_q,    clk_d;
  logic                  ws_q,     ws_d;
  logic                  uf_q,     uf_d;
  logic [7:0]            ufcnt_q,  ufcnt_d;

  // -------------------------------------------------------------------------
  // Control decode
  // -------------------------------------------------------------------------
  logic                  full_s;
  logic                  empty_s;
  logic                  load_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  idle_insert_s;
  logic                  in_ready_s;
  logic [DW-1:0]         pop_word_s;
  logic [WORD_WIDTH-1:0] load_word_s [NUM_CHANNELS];

  assign full_s        = (count_q == FULL_LVL);
  assign empty_s       = (count_q == '0);
  // reset_n_q keeps in_ready low for one cycle after release; no pass-through when full.
  assign in_ready_s    = reset_n_q & ~full_s;
  assign load_s        = (beat_q == LAST_BEAT);
  assign push_s        = in_valid_i & in_ready_s;
  // Pops only look at the pre-edge level, so a word pushed into an empty FIFO
  // on a load edge waits for the following load (no bypass).
  assign pop_s         = load_s & enable_i & ~empty_s;
  assign idle_insert_s = load_s & enable_i & empty_s;
  assign pop_word_s    = mem_q[rd_ptr_q];

  // Select the symbol each channel loads at a word boundary, applying bit order.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      load_word_s[c] = IDLE_WORD;
      if (pop_s) begin
        if (MSB_FIRST) begin
          load_word_s[c] = bit_reverse_f(pop_word_s[c*WORD_WIDTH +: WORD_WIDTH]);
        end else begin
          load_word_s[c] = pop_word_s[c*WORD_WIDTH +: WORD_WIDTH];
        end
      end else begin
        if (MSB_FIRST) begin
          load_word_s[c] = bit_reverse_f(IDLE_WORD);
        end else begin
          load_word_s[c] = IDLE_WORD;
        end
      end
    end
  end

  // Next-state logic for beat counter, FIFO pointers/level, shifters and status.
  always_comb begin
    beat_d   = beat_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    clk_d    = clk_q;
    ws_d     = 1'b0;
    uf_d     = uf_q;
    ufcnt_d  = ufcnt_q;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      shift_d[c] = shift_q[c];
    end

    // Beat counter and serial shifters
    if (load_s) begin
      beat_d = '0;
      clk_d  = CLK_PATTERN;
      ws_d   = 1'b1;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        shift_d[c] = load_word_s[c];
      end
    end else begin
      beat_d = beat_q + CNT_W'(1);
      clk_d  = clk_q >> LANE_WIDTH;
      ws_d   = 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        shift_d[c] = shift_q[c] >> LANE_WIDTH;
      end
    end

    // FIFO pointers (power-of-two depth wraps naturally)
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // FIFO level
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase

    // Underflow flag and saturating counter
    uf_d = uf_q | idle_insert_s;
    if (idle_insert_s && (ufcnt_q != 8'hFF)) begin
      ufcnt_d = ufcnt_q + 8'd1;
    end else begin
      ufcnt_d = ufcnt_q;
    end
  end

  // State register with synchronous active-low reset; also flushes the FIFO.
  always_ff @(posedge clk_pixel_x5_i) begin
    if (!reset_n_i) begin
      reset_n_q <= 1'b0;
      beat_q    <= LAST_BEAT;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      clk_q     <= '0;
      ws_q      <= 1'b0;
      uf_q      <= 1'b0;
      ufcnt_q   <= 8'd0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        shift_q[c] <= '0;
      end
    end else begin
      reset_n_q <= 1'b1;
      beat_q    <= beat_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      clk_q     <= clk_d;
      ws_q      <= ws_d;
      uf_q      <= uf_d;
      ufcnt_q   <= ufcnt_d;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        shift_q[c] <= shift_d[c];
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers are cleared.
  always_ff @(posedge clk_pixel_x5_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: low slice of each shift register, plus status registers
  // -------------------------------------------------------------------------
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_lane
    assign lane_out_o[c*LANE_WIDTH +: LANE_WIDTH] = shift_q[c][LANE_WIDTH-1:0];
  end

  assign clk_lane_o      = clk_q[LANE_WIDTH-1:0];
  assign word_start_o    = ws_q;
  assign underflow_o     = uf_q;
  assign underflow_cnt_o = ufcnt_q;
  assign fifo_level_o    = count_q;
  assign in_ready_o      = in_ready_s;

endmodule
